// File: rtl/irq_priority_encoder_pkg.sv
// Shared types and helpers for the interrupt priority encoder.
// Holds the selection-mode enum, the channel ceiling and bit-vector helpers.
package irq_priority_encoder_pkg;

    localparam int N_MAX = 64;

    typedef enum logic {
        SEL_FIXED = 1'b0,
        SEL_RR    = 1'b1
    } sel_mode_e;

    function automatic logic [6:0] popcount(input logic [N_MAX-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < N_MAX; i++) begin
            c = c + 7'((v >> i) & N_MAX'(1));
        end
        return c;
    endfunction

    function automatic logic [N_MAX-1:0] onehot(input logic [5:0] idx);
        return N_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_priority_encoder_prio_select.sv
// Combinational pick of the first set bit, searching downward from a start
// index and wrapping from 0 to N-1. Fixed mode always starts at N-1.
module prio_select
    import irq_priority_encoder_pkg::*;
#(
    parameter int        N    = 8,
    parameter int        W    = $clog2(N),
    parameter sel_mode_e MODE = SEL_FIXED
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    int          first;
    int          pos;
    logic [N-1:0] shifted;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        shifted = '0;
        first   = (MODE == SEL_FIXED) ? N - 1 : int'(start);
        for (int k = 0; k < N; k++) begin
            pos = first - k;
            if (pos < 0) begin
                pos = pos + N;
            end
            shifted = vec >> pos;
            if (!found && shifted[0]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/irq_priority_encoder.sv
// Sticky-request interrupt priority encoder with registered grant and count.
// Define IRQ_PRIO_RR_EN to replace fixed priority with round-robin selection.
module irq_priority_encoder
    import irq_priority_encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [W:0]   pend_cnt
);

    logic [N-1:0] pend;
    logic [N-1:0] pend_next;
    logic [N-1:0] clr;
    logic         take;
    logic         rearb;
    logic [W-1:0] start;
    logic         found;
    logic [W-1:0] sel_idx;

    assign take  = valid & ack;
    assign rearb = ~valid | ack;

    // A new request for the channel being acked survives the clear (set wins).
    assign clr       = take ? N'(onehot(6'(code))) : '0;
    assign pend_next = (pend & ~clr) | (en ? req : '0);

`ifdef IRQ_PRIO_RR_EN
    localparam sel_mode_e MODE = SEL_RR;

    logic [W-1:0] last;
    logic [W-1:0] last_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= '0;
        end else if (take) begin
            last <= code;
        end
    end

    // The channel acked this edge already counts as "last" for the next pick.
    assign last_eff = take ? code : last;
    assign start    = (last_eff == '0) ? W'(N - 1) : last_eff - W'(1);
`else
    localparam sel_mode_e MODE = SEL_FIXED;

    assign start = W'(N - 1);
`endif

    prio_select #(
        .N    (N),
        .W    (W),
        .MODE (MODE)
    ) u_select (
        .vec   (pend_next),
        .start (start),
        .found (found),
        .idx   (sel_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            code     <= '0;
            valid    <= 1'b0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= (W+1)'(popcount(N_MAX'(pend_next)));
            if (rearb) begin
                valid <= found;
                code  <= found ? sel_idx : '0;
            end
        end
    end

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Randomized and directed bench for irq_priority_encoder (N=8) against a
// behavioural model; follows IRQ_PRIO_RR_EN to choose the expected policy.
module tb_irq_priority_encoder;

    localparam int N = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [3:0] pend_cnt;

    int n_cmp;
    int n_fail;

    bit m_pend [N];
    bit m_valid;
    int m_code;
    int m_cnt;
    int m_last;
`ifdef IRQ_PRIO_RR_EN
    bit rr_mode = 1'b1;
`else
    bit rr_mode = 1'b0;
`endif

    irq_priority_encoder #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .ack      (ack),
        .code     (code),
        .valid    (valid),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_code  = 0;
        m_cnt   = 0;
        m_last  = 0;
    endtask

    // Model: sticky pending bits, grant held until acked, then the first
    // pending channel in priority order becomes the new grant.
    task automatic model_step(bit e, logic [7:0] r, bit a);
        int ch;
        bool_rearb: begin end
        if (m_valid && a) begin
            m_pend[m_code] = 1'b0;
            m_last = m_code;
        end
        if (e) for (int i = 0; i < N; i++) if (r[i]) m_pend[i] = 1'b1;
        m_cnt = 0;
        for (int i = 0; i < N; i++) m_cnt += int'(m_pend[i]);
        if (!m_valid || a) begin
            m_valid = 1'b0;
            m_code  = 0;
            for (int k = 1; k <= N; k++) begin
                ch = rr_mode ? (((m_last - k) % N) + N) % N : N - k;
                if (m_pend[ch]) begin
                    m_valid = 1'b1;
                    m_code  = ch;
                    break;
                end
            end
        end
    endtask

    task automatic step(bit e, logic [7:0] r, bit a);
        en  = e;
        req = r;
        ack = a;
        @(posedge clk);
        model_step(e, r, a);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; req = '0; ack = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({valid, code, pend_cnt} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_initial: got valid=%0b code=%0d cnt=%0d, need 0/0/0", valid, code, pend_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b1, 8'h30, 1'b0);
        n_cmp++;
        if ({valid, code, pend_cnt} !== {1'b1, 3'd5, 4'd2}) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_grant: got valid=%0b code=%0d cnt=%0d, need 1/5/2", valid, code, pend_cnt);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({valid, code, pend_cnt} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got valid=%0b code=%0d cnt=%0d, need 0/0/0", valid, code, pend_cnt);
        end
        en = 1'b0; req = '0; ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if ({valid, code, pend_cnt} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: got valid=%0b code=%0d cnt=%0d, need 0/0/0", valid, code, pend_cnt);
        end
        step(1'b1, 8'h02, 1'b1);
        n_cmp++;
        if ({valid, code, pend_cnt} !== {1'b1, 3'd1, 4'd1}) begin
            n_fail++;
            $display("[TB] FAIL post_reset_grant: got valid=%0b code=%0d cnt=%0d, need 1/1/1", valid, code, pend_cnt);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_drain();
        logic [7:0] exp [4];
        exp[0] = {1'b1, 3'd7, 4'd3};
        exp[1] = {1'b1, 3'd5, 4'd2};
        exp[2] = {1'b1, 3'd2, 4'd1};
        exp[3] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) step(1'b1, 8'hA4, 1'b1);
            else        step(1'b1, 8'h00, 1'b1);
            n_cmp++;
            if ({valid, code, pend_cnt} !== exp[c]) begin
                n_fail++;
                $display("[TB] FAIL drain_%0d: got valid=%0b code=%0d cnt=%0d, need %0b/%0d/%0d",
                         c, valid, code, pend_cnt, exp[c][7], exp[c][6:4], exp[c][3:0]);
            end
        end
    endtask

    task automatic test_hold();
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h40, 1'b0);
        n_cmp++;
        if ({valid, code, pend_cnt} !== {1'b1, 3'd2, 4'd2}) begin
            n_fail++;
            $display("[TB] FAIL hold_code: got valid=%0b code=%0d cnt=%0d, need 1/2/2", valid, code, pend_cnt);
        end
        step(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (code !== 3'd2) begin
            n_fail++;
            $display("[TB] FAIL hold_idle_cycle: got code=%0d, need 2", code);
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if ({valid, code, pend_cnt} !== {1'b1, 3'd6, 4'd1}) begin
            n_fail++;
            $display("[TB] FAIL hold_after_ack: got valid=%0b code=%0d cnt=%0d, need 1/6/1", valid, code, pend_cnt);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_enable();
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 8'hFF, 1'b0);
            n_cmp++;
            if ({valid, pend_cnt} !== 5'b0_0000) begin
                n_fail++;
                $display("[TB] FAIL en_low_%0d: got valid=%0b cnt=%0d, need 0/0", c, valid, pend_cnt);
            end
        end
        step(1'b1, 8'h01, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        n_cmp++;
        if ({valid, code, pend_cnt} !== {1'b1, 3'd0, 4'd1}) begin
            n_fail++;
            $display("[TB] FAIL en_low_pending: got valid=%0b code=%0d cnt=%0d, need 1/0/1", valid, code, pend_cnt);
        end
        step(1'b0, 8'hFF, 1'b1);
        n_cmp++;
        if ({valid, code, pend_cnt} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL en_low_served: got valid=%0b code=%0d cnt=%0d, need 0/0/0", valid, code, pend_cnt);
        end
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ack_while_idle: got valid=%0b, need 0", valid);
        end
    endtask

    task automatic test_same_channel();
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h08, 1'b1);
        n_cmp++;
        if ({valid, code, pend_cnt} !== {1'b1, 3'd3, 4'd1}) begin
            n_fail++;
            $display("[TB] FAIL set_wins: got valid=%0b code=%0d cnt=%0d, need 1/3/1", valid, code, pend_cnt);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_all_ones();
        int want;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            step(1'b1, 8'hFF, 1'b1);
            want = rr_mode ? (7 - c + 8) % 8 : 7;
            n_cmp++;
            if ({valid, code, pend_cnt} !== {1'b1, 3'(want), 4'd8}) begin
                n_fail++;
                $display("[TB] FAIL all_ones_%0d: got valid=%0b code=%0d cnt=%0d, need 1/%0d/8",
                         c, valid, code, pend_cnt, want);
            end
        end
        for (int c = 0; c < 9; c++) step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if ({valid, code, pend_cnt} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL all_ones_drained: got valid=%0b code=%0d cnt=%0d, need 0/0/0", valid, code, pend_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        for (int c = 0; c < 400; c++) begin
            r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0));
            n_cmp++;
            if ({valid, code, pend_cnt} !== {m_valid, 3'(m_code), 4'(m_cnt)}) begin
                n_fail++;
                $display("[TB] FAIL random_%0d: got valid=%0b code=%0d cnt=%0d, need %0b/%0d/%0d",
                         c, valid, code, pend_cnt, m_valid, m_code, m_cnt);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_drain();
        test_hold();
        test_enable();
        test_same_channel();
        test_all_ones();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
